serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit count; SHALL be >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; sampled with start.
REQ-006 b  input  WIDTH  operand B; sampled with start.
REQ-007 cin  input  1  carry-in; sampled with start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid new result.
REQ-010 sum  output  WIDTH  registered result: a+b+cin mod 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 at edge k: latch a, b, cin into operand shift registers and the carry flop, clear the bit counter, go to RUN.
REQ-014 IDLE with start=0: remain in IDLE; no register changes.
REQ-015 RUN, each edge: apply operand LSBs and the carry flop to the full adder.
REQ-016 RUN, each edge: shift r into the MSB of the partial-sum register, store co in the carry flop, shift both operand registers right one bit, increment the counter.
REQ-017 RUN SHALL last exactly WIDTH edges (k+1 .. k+WIDTH); on the WIDTH-th edge, copy the partial sum to sum and the final carry to cout, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH and low otherwise.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 start asserted in RUN or DONE SHALL be ignored; the in-flight operands SHALL NOT change.
REQ-022 sum/cout SHALL hold the previous result throughout a new operation and change only on the completion edge (REQ-017).
REQ-023 Back-to-back: start held continuously SHALL begin a new operation on the first IDLE edge, giving one operation per WIDTH+2 cycles.
REQ-024 Overflow: carry beyond bit WIDTH-1 SHALL appear only on cout; sum wraps mod 2^WIDTH.
REQ-025 WIDTH=1: RUN SHALL last one edge; behaviour SHALL be equivalent to one full-adder evaluation registered.
REQ-026 Counter width SHALL be $clog2(WIDTH)+1 bits so the terminal count cannot wrap.

Reset
REQ-027 rst=1 at an edge SHALL force: state IDLE, busy=0, done=0, sum=0, cout=0, counter/carry/shift registers 0.
REQ-028 rst SHALL take priority over start and all FSM transitions.
REQ-029 rst asserted in RUN SHALL abort the operation: no done pulse, partial result discarded.
REQ-030 After rst deasserts, the next start SHALL be accepted normally.

Structure
REQ-031 The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined once in the shared adder package/include; it SHALL NOT be redefined locally.
REQ-032 Exactly one sub-module, the existing 1-bit full adder fa (i1, i2, ci, r, co), SHALL be instantiated for the per-bit sum.
REQ-033 No combinational path SHALL exist from any input to any output; all outputs SHALL be registered.

Verification (WIDTH=8)
REQ-034 rst=1 two cycles, start=1 -> busy=0, done=0, sum=8'h00, cout=0; no start accepted.
REQ-035 a=8'h5A, b=8'h33, cin=0, one-cycle start at edge k -> busy high for edges k+1..k+8; done high only in cycle after k+8; sum=8'h8D, cout=0.
REQ-036 Carry-chain cases: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-037 Start 8'h10+8'h20, then during RUN drive start=1 with a=8'hAA, b=8'h55 -> first result sum=8'h30; operand change ignored.
REQ-037 (cont.) Second operation begins only after return to IDLE.
REQ-038 Start 8'h0F+8'h01; assert rst at 4th RUN edge -> no done; sum=8'h00, cout=0; then 8'h03+8'h04 -> sum=8'h07.
REQ-039 After 8'h5A+8'h33 completes, start 8'h01+8'h01 -> sum stays 8'h8D until the new completion edge, then becomes 8'h02.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the terminal count WIDTH-1 (and beyond) never wraps.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
//   start, a, b, cin : request and operands (driven by master)
//   busy, done       : progress flags (driven by slave)
//   sum, cout        : registered result (driven by slave)
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_fa.sv
// 1-bit full adder used for the per-bit sum.
//   i1, i2 : operand bits
//   ci     : carry in
//   r      : sum bit
//   co     : carry out
module fa (
    input  logic i1,
    input  logic i2,
    input  logic ci,
    output logic r,
    output logic co
);

    assign r  = i1 ^ i2 ^ ci;
    assign co = (i1 & i2) | (ci & (i1 ^ i2));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result and
// carry-out registered on the last RUN edge, one-cycle done pulse after.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             finish;
    logic             busy_next;
    logic             done_next;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_shifted;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             r;
    logic             co;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    fa u_fa (
        .i1 (a_sh[0]),
        .i2 (b_sh[0]),
        .ci (carry),
        .r  (r),
        .co (co)
    );

    // New sum bit enters at the MSB; written as a shift so WIDTH=1 works.
    assign psum_shifted = (psum >> 1) | (WIDTH'(r) << (WIDTH - 1));
    assign last         = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath controls.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // Operand shifters, carry, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            if (load) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end
            if (step) begin
                psum  <= psum_shifted;
                carry <= co;
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                cnt   <= cnt + CW'(1);
            end
            if (finish) begin
                sum_q  <= psum_shifted;
                cout_q <= co;
            end
            busy_q <= busy_next;
            done_q <= done_next;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases with
// literal expectations plus randomized traffic against a timing/arith model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: accepted request -> W cycles busy -> 1 cycle done -> idle.
    // Result is plain (a + b + cin) split into low W bits and carry.
    int unsigned phase = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic [W-1:0] pend_sum;
    logic         pend_cout;

    always @(posedge clk) begin
        if (rst) begin
            phase  = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (phase == 0) begin
            if (bus.start) begin
                {pend_cout, pend_sum} = {1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.cin);
                phase = 1;
            end
        end else if (phase < W) begin
            phase = phase + 1;
        end else if (phase == W) begin
            phase  = W + 1;
            m_sum  = pend_sum;
            m_cout = pend_cout;
        end else begin
            phase = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-shot operation; also checks latency and that sum holds the old value.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W-1:0] exp_sum, input logic exp_cout,
                      input logic [W-1:0] prev_sum, input string name);
        int  busy_cycles;
        bit  got;
        bit  held;
        tick();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        tick();
        bus.start = 1'b0;
        busy_cycles = 0;
        got  = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cycles++;
                if (bus.sum !== prev_sum) held = 1'b0;
            end
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " busy_cycles"}, 32'(busy_cycles), 32'(W));
        check({name, " sum_held"}, 32'(held), 32'd1);
        check({name, " sum"}, 32'(bus.sum), 32'(exp_sum));
        check({name, " cout"}, 32'(bus.cout), 32'(exp_cout));
    endtask

    initial begin
        int  gap;
        bit  got;

        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b1;
        tick();

        // Per-cycle comparison of all outputs against the model.
        fork
            forever begin
                @(negedge clk);
                tests++;
                if ({bus.busy, bus.done, bus.cout, bus.sum} !==
                    {(phase >= 1 && phase <= W), (phase == W + 1), m_cout, m_sum}) begin
                    fails++;
                    $display("FAIL stream t=%0t busy/done/cout/sum got %b %b %b %02h expected %b %b %b %02h",
                             $time, bus.busy, bus.done, bus.cout, bus.sum,
                             (phase >= 1 && phase <= W), (phase == W + 1), m_cout, m_sum);
                end
            end
        join_none

        tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sum",  32'(bus.sum),  32'h00);
        check("reset cout", 32'(bus.cout), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;

        op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 8'h00, "5A+33");
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8'h8D, "01+01");
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h02, "FF+01");
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, "FF+FF+1");

        // Start held through RUN with new operands: first result unaffected,
        // second operation begins only after returning to IDLE.
        tick();
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.cin   = 1'b0;
        tick();
        bus.a = 8'hAA;
        bus.b = 8'h55;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
        check("held first done", 32'(got), 32'd1);
        check("held first sum", 32'(bus.sum), 32'h30);
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        check("held second done", 32'(got), 32'd1);
        check("back-to-back period", 32'(gap), 32'(W + 2));
        check("held second sum", 32'(bus.sum), 32'hFF);
        check("held second cout", 32'(bus.cout), 32'd0);

        // Reset on the 4th RUN edge aborts the operation.
        tick();
        tick();
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort sum",  32'(bus.sum),  32'h00);
        check("abort cout", 32'(bus.cout), 32'd0);
        tick();
        check("abort no late done", 32'(bus.done), 32'd0);
        op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 8'h00, "03+04");

        // Randomized traffic, including starts during RUN/DONE and rare resets.
        for (int i = 0; i < 1500; i++) begin
            tick();
            rst       = ($urandom_range(0, 149) == 0);
            bus.start = ($urandom_range(0, 3) != 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
